// File: rtl/leg_mem_pkg.sv
// Shared types and constants for the cache-line burst controller.
package leg_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_beat_ctr.sv
// Beat index / completed-beat counter for one burst; idx either wraps within the line or runs linearly.
module mem_beat_ctr #(
  parameter int BLOCK_WORDS = 4,
  parameter bit WRAP        = 1'b0,
  parameter int IW          = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          en,
  input  logic [IW-1:0] start_idx,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [IW:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      count <= '0;
    end else if (load) begin
      idx   <= start_idx;
      count <= '0;
    end else if (en) begin
      count <= count + (IW+1)'(1);
      // Linear mode never needs to roll over: the burst ends on the top word.
      if (WRAP || (idx != IW'(BLOCK_WORDS - 1)))
        idx <= idx + IW'(1);
    end
  end

  assign last = (count == (IW+1)'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_burst_ctrl.sv
// Cache line fill / writeback burst controller: IDLE -> BURST (one beat per mem_valid) -> DONE.
// Define LEG_MEM_WRAP_EN for critical-word-first bursts that wrap within the line.
module mem_burst_ctrl
  import leg_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int AW          = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [AW-1:0]                  req_addr,
  input  logic [31:0]                    wdata,
  output logic                           w_ack,
  output logic [31:0]                    rdata,
  output logic                           rvalid,
  output logic [$clog2(BLOCK_WORDS)-1:0] rbeat,
  output logic                           done,
  output logic [AW-1:0]                  mem_a,
  output logic [31:0]                    mem_wd,
  output logic                           mem_re,
  output logic                           mem_we,
  output logic                           mem_hsel,
  input  logic [31:0]                    mem_rd,
  input  logic                           mem_valid
);

  localparam int IW    = $clog2(BLOCK_WORDS);
  localparam int BSH   = $clog2(WORD_BYTES);
  localparam int LINE_W = IW + BSH;

  state_t        state;
  logic          write;
  logic [AW-1:0] base;
  logic [IW-1:0] idx;
  logic [IW-1:0] start_idx;
  logic          last;
  logic          accept;
  logic          beat_done;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign beat_done = (state == BURST) && mem_valid;

`ifdef LEG_MEM_WRAP_EN
  localparam bit WRAP = 1'b1;
  assign start_idx = req_addr[LINE_W-1:BSH];
`else
  localparam bit WRAP = 1'b0;
  assign start_idx = '0;
`endif

  mem_beat_ctr #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .WRAP        (WRAP),
    .IW          (IW)
  ) u_beat_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .en        (beat_done),
    .start_idx (start_idx),
    .idx       (idx),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      write  <= 1'b0;
      base   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      rbeat  <= '0;
      done   <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BURST;
            write <= req_write;
            base  <= req_addr & {{(AW-LINE_W){1'b1}}, {LINE_W{1'b0}}};
          end
        end
        BURST: begin
          if (mem_valid) begin
            if (!write) begin
              rdata  <= mem_rd;
              rbeat  <= idx;
              rvalid <= 1'b1;
            end
            // done is registered alongside the last rvalid so the two coincide.
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is decoded straight from registered state, so it holds steady through stalls.
  assign mem_hsel = (state == BURST);
  assign mem_re   = mem_hsel && !write;
  assign mem_we   = mem_hsel && write;
  assign w_ack    = mem_we && mem_valid;
  assign mem_a    = base + (AW'(idx) * AW'(WORD_BYTES));
  assign mem_wd   = wdata;

endmodule
